// File: rtl/display_sched_pkg.sv
// rtl/display_sched_pkg.sv - shared types and constants for the display scheduler
package display_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam logic [15:0] BLANK_WORD_DEFAULT = 16'h0000;

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter that saturates at zero
module hold_timer #(
  parameter int HOLD_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic zero
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin owner of a shared LED display word
// Each grant shows the winner's word for HOLD_CYCLES cycles; idle shows BLANK_WORD.
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int          HOLD_CYCLES = 256,
  parameter logic [15:0] BLANK_WORD  = BLANK_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        ack_b,
  output logic [15:0] signal_to_display,
  output logic        owner,
  output logic        showing
);

  state_e      state_q, state_d;
  logic [15:0] sig_q, sig_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        showing_q, showing_d;
  logic        timer_load;
  logic        timer_zero;
  logic        grant_point;
  logic        pick_b;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .zero (timer_zero)
  );

  // The timer sits at zero in IDLE, so a grant point is simply "idle or hold expired".
  assign grant_point = (state_q == IDLE) || timer_zero;
  assign pick_b      = req_b && (!req_a || (last_grant_q == SRC_A));

  always_comb begin
    state_d      = state_q;
    sig_d        = sig_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    timer_load   = 1'b0;
    if (grant_point) begin
      if (req_a || req_b) begin
        state_d      = HOLD;
        timer_load   = 1'b1;
        sig_d        = pick_b ? data_b : data_a;
        owner_d      = pick_b ? SRC_B : SRC_A;
        last_grant_d = pick_b ? SRC_B : SRC_A;
        ack_a_d      = !pick_b;
        ack_b_d      = pick_b;
      end else begin
        state_d = IDLE;
        sig_d   = BLANK_WORD;
      end
    end
    showing_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sig_q        <= BLANK_WORD;
      owner_q      <= SRC_A;
      last_grant_q <= SRC_B;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      showing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sig_q        <= sig_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      showing_q    <= showing_d;
    end
  end

  assign signal_to_display = sig_q;
  assign owner             = owner_q;
  assign showing           = showing_q;
  assign ack_a             = ack_a_q;
  assign ack_b             = ack_b_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed vector bench for display_scheduler
module tb_display_scheduler;
  import display_sched_pkg::*;

  localparam logic [15:0] WA = 16'hA194;
  localparam logic [15:0] WB = 16'hCC10;
  localparam logic [15:0] BL = 16'h0000;

  logic        clk;
  logic        reset;
  logic        req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        ack_a, ack_b;
  logic [15:0] signal_to_display;
  logic        owner, showing;

  int tests;
  int fails;
  logic prev_ack_a, prev_ack_b;

  typedef struct {
    logic        rst;
    logic        ra;
    logic [15:0] da;
    logic        rb;
    logic [15:0] db;
    logic [15:0] e_sig;
    logic        e_own;
    logic        e_show;
    logic        e_aa;
    logic        e_ab;
  } vec_t;

  vec_t vecs[$];

  display_scheduler #(
    .HOLD_CYCLES(4),
    .BLANK_WORD (16'h0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_a            (req_a),
    .data_a           (data_a),
    .ack_a            (ack_a),
    .req_b            (req_b),
    .data_b           (data_b),
    .ack_b            (ack_b),
    .signal_to_display(signal_to_display),
    .owner            (owner),
    .showing          (showing)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic vec_t mk(logic rst, logic ra, logic rb, logic [15:0] es,
                              logic eo, logic esh, logic eaa, logic eab);
    vec_t v;
    v.rst = rst; v.ra = ra; v.da = WA; v.rb = rb; v.db = WB;
    v.e_sig = es; v.e_own = eo; v.e_show = esh; v.e_aa = eaa; v.e_ab = eab;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_invariants(input string tag);
    check({tag, " acks_exclusive"}, 16'(ack_a & ack_b), 16'h0);
    check({tag, " ack_a_width"}, 16'(ack_a & prev_ack_a), 16'h0);
    check({tag, " ack_b_width"}, 16'(ack_b & prev_ack_b), 16'h0);
    check({tag, " showing_vs_state"}, 16'(showing), 16'(dut.state_q == HOLD));
    prev_ack_a = ack_a;
    prev_ack_b = ack_b;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int waited;
    tests = 0;
    fails = 0;
    prev_ack_a = 1'b0;
    prev_ack_b = 1'b0;
    reset  = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    data_a = WA;
    data_b = WB;

    // Twenty reset cycles with no requests: everything stays blank and quiet.
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("rst%0d sig", i), signal_to_display, BL);
      check($sformatf("rst%0d show", i), 16'(showing), 16'h0);
      check($sformatf("rst%0d acks", i), {14'h0, ack_a, ack_b}, 16'h0);
      check($sformatf("rst%0d owner", i), 16'(owner), 16'h0);
      check_invariants($sformatf("rst%0d", i));
    end

    // Tie held from reset: A first, then B, then A, back-to-back.
    vecs.push_back(mk(1, 1, 1, BL, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, WA, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, WA, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, WB, 1, 1, 0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, WB, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, WA, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, WA, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, BL, 0, 0, 0, 0));
    // Single A, then B raised mid-hold waits for A's counter to expire.
    vecs.push_back(mk(0, 1, 0, WA, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, WA, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, WB, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, WB, 1, 1, 0, 0));
    // Reset pulse during B hold, then a tie goes to A.
    vecs.push_back(mk(1, 0, 0, BL, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, WA, 0, 1, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, WA, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, BL, 0, 0, 0, 0));
    // Owner keeps B in idle after a B-only hold expires.
    vecs.push_back(mk(0, 0, 1, WB, 1, 1, 0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, WB, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, BL, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, BL, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      req_a = vecs[i].ra;
      data_a = vecs[i].da;
      req_b = vecs[i].rb;
      data_b = vecs[i].db;
      step();
      check($sformatf("v%0d sig", i), signal_to_display, vecs[i].e_sig);
      check($sformatf("v%0d owner", i), 16'(owner), 16'(vecs[i].e_own));
      check($sformatf("v%0d showing", i), 16'(showing), 16'(vecs[i].e_show));
      check($sformatf("v%0d ack_a", i), 16'(ack_a), 16'(vecs[i].e_aa));
      check($sformatf("v%0d ack_b", i), 16'(ack_b), 16'(vecs[i].e_ab));
      check_invariants($sformatf("v%0d", i));
    end

    // Request present while reset is high is not honoured until reset drops.
    reset  = 1'b1;
    req_a  = 1'b1;
    data_a = 16'h1234;
    req_b  = 1'b0;
    step();
    check("seq_rst ack_a", 16'(ack_a), 16'h0);
    check("seq_rst sig", signal_to_display, BL);
    check_invariants("seq_rst");
    reset  = 1'b0;
    waited = 0;
    while (!ack_a && waited < 10) begin
      step();
      waited++;
      check_invariants($sformatf("seq_wait%0d", waited));
    end
    check("seq_ack_latency", 16'(waited), 16'd1);
    check("seq_sig", signal_to_display, 16'h1234);
    req_a = 1'b0;

    // Reset during a hold with A still requesting: no ack, blank, owner A.
    step();
    check_invariants("seq_hold");
    req_a = 1'b1;
    reset = 1'b1;
    step();
    check("seq_abort ack_a", 16'(ack_a), 16'h0);
    check("seq_abort sig", signal_to_display, BL);
    check("seq_abort show", 16'(showing), 16'h0);
    check_invariants("seq_abort");
    reset = 1'b0;
    req_a = 1'b0;
    step();
    check("seq_after_abort sig", signal_to_display, BL);
    check_invariants("seq_after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
